// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings, sequencer state type and instruction field
// positions shared by the sequencer and its decoder.
package alu_seq_pkg;

  localparam logic [4:0] OP_ROLV = 5'b00000;
  localparam logic [4:0] OP_RORV = 5'b00001;
  localparam logic [4:0] OP_NOT  = 5'b00010;
  localparam logic [4:0] OP_NOR  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b10000;
  localparam logic [4:0] OP_ADDI = 5'b10100;
  localparam logic [4:0] OP_BGE  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RS_HI  = 26;
  localparam int RS_LO  = 22;
  localparam int RT_HI  = 21;
  localparam int RT_LO  = 17;
  localparam int RD_HI  = 16;
  localparam int RD_LO  = 12;
  localparam int IMM_HI = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // 17-bit immediate to 32-bit two's complement
  function automatic logic [31:0] sext_imm(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: opcode legality, op class flags and register write target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the instruction register directly.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] i_op,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output logic       o_legal,
  output logic       o_is_halt,
  output logic       o_is_bge,
  output logic       o_is_addi,
  output logic [4:0] o_wa
);

  // Classify the opcode; ADDI writes rt, every other writing op writes rd
  always_comb begin
    o_legal   = 1'b0;
    o_is_halt = 1'b0;
    o_is_bge  = 1'b0;
    o_is_addi = 1'b0;
    case (i_op)
      OP_ROLV, OP_RORV, OP_NOT, OP_NOR, OP_ADD: o_legal = 1'b1;
      OP_ADDI: begin
        o_legal   = 1'b1;
        o_is_addi = 1'b1;
      end
      OP_BGE: begin
        o_legal  = 1'b1;
        o_is_bge = 1'b1;
      end
      OP_HALT: begin
        o_legal   = 1'b1;
        o_is_halt = 1'b1;
      end
      default: ;
    endcase
    o_wa = o_is_addi ? i_rt : i_rd;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer driving imem, register file and ALU.
// Latency: 4 cycles per ALU/ADDI op, 3 per BGE, plus one cycle per imem_ack wait cycle.
// Backpressure: imem_req/imem_addr held until imem_ack; HALT is terminal until reset.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] alu_i1,
  output logic [31:0] alu_i2,
  output logic [4:0]  alu_sel,
  input  logic [31:0] alu_o,
  input  logic        alu_zero,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_result;
  logic [31:0] r_retired;
  logic        r_halted;
  logic        r_illegal;
  logic        r_run;

  logic [4:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_wa;
  logic [31:0] w_imm;
  logic        w_legal;
  logic        w_is_halt;
  logic        w_is_bge;
  logic        w_is_addi;
  logic        w_fire;

  assign w_op   = r_ir[OP_HI:OP_LO];
  assign w_rs   = r_ir[RS_HI:RS_LO];
  assign w_rt   = r_ir[RT_HI:RT_LO];
  assign w_rd   = r_ir[RD_HI:RD_LO];
  assign w_imm  = sext_imm(r_ir[IMM_HI:0]);
  // An ack only counts while the request is actually being driven
  assign w_fire = (r_state == ST_FETCH) && r_run && imem_ack;

  alu_seq_decode u_decode (
    .i_op      (w_op),
    .i_rt      (w_rt),
    .i_rd      (w_rd),
    .o_legal   (w_legal),
    .o_is_halt (w_is_halt),
    .o_is_bge  (w_is_bge),
    .o_is_addi (w_is_addi),
    .o_wa      (w_wa)
  );

  assign imem_addr = r_pc;
  assign rf_ra1    = w_rs;
  assign rf_ra2    = w_rt;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign retired   = r_retired;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Keeps imem_req low through reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Next-state and per-state output drive; everything idles at zero by default
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = 5'd0;
    rf_wd       = 32'd0;
    alu_sel     = 5'd0;
    alu_i1      = 32'd0;
    alu_i2      = 32'd0;
    case (r_state)
      ST_FETCH: begin
        imem_req = r_run;
        if (r_run && imem_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (!w_legal || w_is_halt) w_state_nxt = ST_HALT;
        else                       w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_sel     = w_op;
        alu_i1      = rf_rd1;
        alu_i2      = w_is_addi ? w_imm : rf_rd2;
        w_state_nxt = w_is_bge ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        rf_wa       = w_wa;
        rf_wd       = r_result;
        rf_we       = (w_wa != 5'd0);
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Architectural state: ir capture, ALU result, pc update, retire count, halt flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_result  <= 32'd0;
      r_retired <= 32'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (w_fire) r_ir <= imem_rdata;
        ST_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
          end else if (w_is_halt) begin
            r_halted  <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_result <= alu_o;
          if (w_is_bge) begin
            r_pc      <= alu_zero ? (r_pc + 32'd1 + w_imm) : (r_pc + 32'd1);
            r_retired <= r_retired + 32'd1;
          end
        end
        ST_WB: begin
          r_pc      <= r_pc + 32'd1;
          r_retired <= r_retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized instruction stream against an ISA-level model;
// register writes are checked by a scoreboard monitor, fetch/exec/halt/reset
// behaviour by the stimulus process.
module tb_alu_sequencer;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [4:0] T_ROLV = 5'b00000, T_RORV = 5'b00001, T_NOT = 5'b00010,
                         T_NOR = 5'b00011, T_ADD = 5'b10000, T_ADDI = 5'b10100,
                         T_BGE = 5'b11000, T_HALT = 5'b11111;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] alu_i1, alu_i2;
  logic [4:0]  alu_sel;
  logic [31:0] alu_o;
  logic        alu_zero;
  logic        halted, illegal;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  wr_t         exp_q[$];
  logic [31:0] mdl_regs[32];
  logic [31:0] mdl_pc;
  logic [31:0] mdl_retired;
  logic [4:0]  last_tgt;
  logic [31:0] last_old;
  bit          lat_pending;
  int          lat_exp;
  int          hs_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_o(alu_o), .alu_zero(alu_zero),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0 : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234);
  endfunction

  // Environment ALU: rotates take their amount from the low 5 bits of operand 2
  function automatic logic [31:0] alu_fn(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [31:0] r;
    d = {a, a};
    case (sel)
      T_ROLV: begin d = d << b[4:0]; r = d[63:32]; end
      T_RORV: begin d = d >> b[4:0]; r = d[31:0]; end
      T_NOT:  r = ~a;
      T_NOR:  r = ~(a | b);
      T_ADD, T_ADDI: r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  // Environment register file and ALU
  logic [31:0] rf[32];
  bit rf_loaded;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      rf_loaded <= 1'b1;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
  end
  assign rf_rd1   = rf[rf_ra1];
  assign rf_rd2   = rf[rf_ra2];
  assign alu_o    = alu_fn(alu_sel, alu_i1, alu_i2);
  assign alu_zero = (alu_sel == T_BGE) ? ($signed(alu_i1) >= $signed(alu_i2)) : (alu_o == 32'h0);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 12'h000};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [16:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0] ops[7];
    ops = '{T_ROLV, T_RORV, T_NOT, T_NOR, T_ADD, T_ADDI, T_BGE};
    return {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 17'($urandom)};
  endfunction

  // ISA-level model: retire one instruction, queue its register write.
  // kind: 0 = writing op, 1 = branch, 2 = halt, 3 = illegal
  task automatic model_issue(input logic [31:0] insn, output int kind,
                             output logic [4:0] e_sel, output logic [31:0] e_i1, output logic [31:0] e_i2);
    logic [4:0]  op, rs, rt, rd, tgt;
    logic [31:0] imm, a, b, res;
    op  = insn[31:27];
    rs  = insn[26:22];
    rt  = insn[21:17];
    rd  = insn[16:12];
    imm = {{15{insn[16]}}, insn[16:0]};
    a   = mdl_regs[rs];
    b   = mdl_regs[rt];
    e_sel = op; e_i1 = a; e_i2 = b;
    kind = 0; tgt = rd; res = 32'h0;
    case (op)
      T_ROLV, T_RORV, T_NOT, T_NOR, T_ADD: res = alu_fn(op, a, b);
      T_ADDI: begin e_i2 = imm; res = a + imm; tgt = rt; end
      T_BGE:  kind = 1;
      T_HALT: kind = 2;
      default: kind = 3;
    endcase
    if (kind == 1) begin
      mdl_pc = ($signed(a) >= $signed(b)) ? (mdl_pc + 32'd1 + imm) : (mdl_pc + 32'd1);
      mdl_retired++;
    end else if (kind == 0) begin
      last_tgt = tgt;
      last_old = mdl_regs[tgt];
      if (tgt != 5'd0) begin
        exp_q.push_back('{wa: tgt, wd: res});
        mdl_regs[tgt] = res;
      end
      mdl_pc = mdl_pc + 32'd1;
      mdl_retired++;
    end
  endtask

  // Wait for the next fetch request and check where it points
  task automatic sync_fetch();
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    check("fetch_req", imem_req, 1'b1);
    if (lat_pending) begin
      check("latency", 32'(cyc - hs_cyc), 32'(lat_exp));
      lat_pending = 0;
    end
    check("fetch_pc", imem_addr, mdl_pc);
    check("retired", retired, mdl_retired);
  endtask

  // One fetch with wait_n withheld ack cycles; returns at the EXEC (or HALT) cycle
  task automatic fetch_one(input logic [31:0] insn, input int wait_n);
    int kind;
    logic [4:0]  es;
    logic [31:0] ei1, ei2, a0;
    sync_fetch();
    if (imem_req !== 1'b1) return;
    a0 = imem_addr;
    for (int w = 0; w < wait_n; w++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, a0);
    end
    imem_ack = 1'b1;
    imem_rdata = insn;
    hs_cyc = cyc;
    model_issue(insn, kind, es, ei1, ei2);
    @(negedge clk);
    // stray ack while no request is outstanding must be ignored
    imem_ack = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    check("decode_req", imem_req, 1'b0);
    check("decode_alu_sel", alu_sel, 5'd0);
    check("decode_alu_i1", alu_i1, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    if (kind <= 1) begin
      check("exec_alu_sel", alu_sel, es);
      check("exec_alu_i1", alu_i1, ei1);
      check("exec_alu_i2", alu_i2, ei2);
      check("exec_req", imem_req, 1'b0);
      lat_pending = 1;
      lat_exp = (kind == 1) ? 3 : 4;
    end else begin
      check("halt_halted", halted, 1'b1);
      check("halt_illegal", illegal, (kind == 3) ? 1'b1 : 1'b0);
      lat_pending = 0;
    end
  endtask

  task automatic halt_watch(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check("halt_req", imem_req, 1'b0);
      check("halt_flag", halted, 1'b1);
      check("halt_we", rf_we, 1'b0);
      check("halt_retired", retired, mdl_retired);
    end
    imem_ack = 1'b0;
  endtask

  // Assert reset mid-cycle and check the asynchronous effects; model restarts
  task automatic assert_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_we", rf_we, 1'b0);
    check("rst_retired", retired, 32'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_alu_sel", alu_sel, 5'd0);
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    mdl_pc = RST_PC;
    mdl_retired = 32'd0;
    exp_q.delete();
    lat_pending = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_req_low", imem_req, 1'b0);
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor for register writes
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write actual wa=%0d wd=%h required none", rf_wa, rf_wd);
        end else begin
          w = exp_q.pop_front();
          check("wb_wa", rf_wa, w.wa);
          check("wb_wd", rf_wd, w.wd);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    lat_pending = 0;
    for (int i = 0; i < 32; i++) mdl_regs[i] = init_val(i);
    mdl_pc = RST_PC;
    mdl_retired = 0;
    last_tgt = 0;
    last_old = 0;

    assert_reset();
    release_reset();

    // directed: ADD 5+7, ADDI with all-ones immediate, BGE taken/not taken at pc 10/9
    fetch_one(enc_i(T_ADDI, 5'd0, 5'd1, 17'd5), 0);
    fetch_one(enc_i(T_ADDI, 5'd0, 5'd2, 17'd7), 0);
    fetch_one(enc_r(T_ADD, 5'd1, 5'd2, 5'd3), 0);
    fetch_one(enc_i(T_ADDI, 5'd0, 5'd1, 17'd1), 0);
    fetch_one(enc_i(T_ADDI, 5'd1, 5'd2, 17'h1FFFF), 3);
    fetch_one(enc_i(T_ADDI, 5'd0, 5'd1, 17'd3), 0);
    fetch_one(enc_i(T_ADDI, 5'd0, 5'd2, 17'd3), 0);
    fetch_one(enc_r(T_NOT, 5'd1, 5'd0, 5'd4), 0);
    fetch_one(enc_r(T_NOR, 5'd1, 5'd3, 5'd5), 1);
    fetch_one(enc_r(T_ROLV, 5'd3, 5'd1, 5'd6), 0);
    fetch_one(enc_i(T_BGE, 5'd1, 5'd2, 17'h1FFFE), 0);
    fetch_one(enc_i(T_BGE, 5'd1, 5'd3, 17'h1FFFE), 0);

    repeat (40) fetch_one(rand_insn(), $urandom_range(0, 2));
    fetch_one(enc_r(T_HALT, 5'd0, 5'd0, 5'd0), 0);
    halt_watch(20);

    assert_reset();
    release_reset();
    repeat (40) fetch_one(rand_insn(), $urandom_range(0, 2));
    fetch_one(enc_r(5'b01111, 5'd1, 5'd2, 5'd3), 1);
    halt_watch(20);

    // reset during the write-back of an ADD
    assert_reset();
    release_reset();
    repeat (10) fetch_one(rand_insn(), $urandom_range(0, 1));
    fetch_one(enc_r(T_ADD, 5'd1, 5'd2, 5'd3), 0);
    @(negedge clk);
    check("wb_we_before_reset", rf_we, 1'b1);
    mdl_regs[last_tgt] = last_old;
    assert_reset();
    release_reset();

    // reset while a fetch is waiting for its ack
    repeat (10) fetch_one(rand_insn(), $urandom_range(0, 2));
    sync_fetch();
    assert_reset();
    release_reset();
    repeat (15) fetch_one(rand_insn(), $urandom_range(0, 2));
    sync_fetch();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
